// File: rtl/mul_err_accum_if.sv
// Sample stream from the approximate multiplier into the error accumulator:
// operand pair, approximate product and a valid/ready handshake.
interface mul_err_accum_if #(
   parameter int W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2*W-1:0]   in_apprx;

   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output in_apprx,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  in_apprx,
      output in_ready
   );
endinterface

// File: rtl/mul_err_accum.sv
// Error-metric accumulator for the 8-bit approximate multiplier.
// Recomputes the exact product for each accepted sample, then accumulates
// error count, signed and absolute error-distance sums and the largest
// |ED| over a window of N_SAMPLES samples. Sums saturate and flag ovf.
module mul_err_accum #(
   parameter int W         = 8,
   parameter int N_SAMPLES = 10000,
   parameter int CNT_W     = 16,
   parameter int SUM_W     = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   mul_err_accum_if.slave     sample_bus,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [SUM_W-1:0]   sum_ed,
   output logic [SUM_W-1:0]   sum_ed_abs,
   output logic [2*W-1:0]     max_ed,
   output logic               ovf
);

   localparam int PW = 2 * W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N_SAMPLES - 1);
   localparam logic [SUM_W-1:0] ABS_MAX    = '1;
   localparam logic [SUM_W-1:0] SIGNED_MAX = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic [SUM_W-1:0] SIGNED_MIN = {1'b1, {(SUM_W-1){1'b0}}};

   logic [1:0]          state;
   logic                accept;
   logic                clear;

   logic                s1_valid;
   logic [PW-1:0]       s1_exact;
   logic [PW-1:0]       s1_apprx;

   logic                s2_valid;
   logic signed [PW:0]  s2_ed;
   logic [PW-1:0]       s2_abs;
   logic                s2_neq;

   logic [SUM_W:0]      sum_wide;
   logic [SUM_W:0]      abs_wide;
   logic [SUM_W-1:0]    sum_next;
   logic [SUM_W-1:0]    abs_next;
   logic                sum_sat;
   logic                abs_sat;

   assign sample_bus.in_ready = (state == RUN);
   assign accept              = sample_bus.in_valid && (state == RUN);
   assign clear               = start && ((state == IDLE) || (state == DONE));
   assign busy                = (state == RUN) || (state == DRAIN);
   assign done                = (state == DONE);

   // Window control: run until the last sample is accepted, then wait for the pipeline to empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (accept && (sample_cnt == LAST_CNT)) state <= DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state <= DONE;
            DONE:    if (start) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Count accepted samples; the window closes as soon as the count reaches N_SAMPLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
      end else if (clear) begin
         sample_cnt <= '0;
      end else if (accept) begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   // Stage 1: capture the exact product and the multiplier's approximation together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_exact <= '0;
         s1_apprx <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_exact <= PW'(sample_bus.in_a) * PW'(sample_bus.in_b);
            s1_apprx <= sample_bus.in_apprx;
         end
      end
   end

   // Stage 2: signed error distance, its magnitude and the mismatch flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_ed    <= '0;
         s2_abs   <= '0;
         s2_neq   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         s2_ed    <= $signed({1'b0, s1_exact}) - $signed({1'b0, s1_apprx});
         s2_abs   <= (s1_exact >= s1_apprx) ? (s1_exact - s1_apprx) : (s1_apprx - s1_exact);
         s2_neq   <= (s1_exact != s1_apprx);
      end
   end

   // Saturating next values for both sums, computed one bit wider to spot overflow.
   always_comb begin
      sum_wide = {sum_ed[SUM_W-1], sum_ed} + {{(SUM_W-PW){s2_ed[PW]}}, s2_ed};
      abs_wide = {1'b0, sum_ed_abs} + {{(SUM_W+1-PW){1'b0}}, s2_abs};
      sum_sat  = (sum_wide[SUM_W] != sum_wide[SUM_W-1]);
      abs_sat  = abs_wide[SUM_W];
      sum_next = sum_wide[SUM_W-1:0];
      abs_next = abs_wide[SUM_W-1:0];
      if (sum_sat) begin
         sum_next = sum_wide[SUM_W] ? SIGNED_MIN : SIGNED_MAX;
      end
      if (abs_sat) begin
         abs_next = ABS_MAX;
      end
   end

   // Stage 3: fold each retiring sample into the window metrics; cleared by a new window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt    <= '0;
         sum_ed     <= '0;
         sum_ed_abs <= '0;
         max_ed     <= '0;
         ovf        <= 1'b0;
      end else if (clear) begin
         err_cnt    <= '0;
         sum_ed     <= '0;
         sum_ed_abs <= '0;
         max_ed     <= '0;
         ovf        <= 1'b0;
      end else if (s2_valid) begin
         err_cnt    <= err_cnt + {{(CNT_W-1){1'b0}}, s2_neq};
         sum_ed     <= sum_next;
         sum_ed_abs <= abs_next;
         if (s2_abs > max_ed) begin
            max_ed <= s2_abs;
         end
         if (sum_sat || abs_sat) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mul_err_accum.sv
// Randomised self-checking bench for mul_err_accum. Two instances share
// the same stimulus: one with a 4-sample window and wide sums, one with a
// 3-sample window and 17-bit sums so saturation is reachable. A window-level
// model tracks accepted samples and computes the metrics arithmetically.
module tb_mul_err_accum;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [15:0] in_apprx;

   logic        busy_a, done_a, ovf_a;
   logic [15:0] scnt_a, ecnt_a, max_a;
   logic [39:0] sum_a, abs_a;

   logic        busy_b, done_b, ovf_b;
   logic [15:0] scnt_b, ecnt_b, max_b;
   logic [16:0] sum_b, abs_b;

   int checks = 0;
   int errors = 0;

   mul_err_accum_if #(.W(8)) bus_a ();
   mul_err_accum_if #(.W(8)) bus_b ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_a     = in_a;
   assign bus_a.in_b     = in_b;
   assign bus_a.in_apprx = in_apprx;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_a     = in_a;
   assign bus_b.in_b     = in_b;
   assign bus_b.in_apprx = in_apprx;

   mul_err_accum #(.W(8), .N_SAMPLES(4), .CNT_W(16), .SUM_W(40)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_bus(bus_a.slave),
      .busy(busy_a), .done(done_a), .sample_cnt(scnt_a), .err_cnt(ecnt_a),
      .sum_ed(sum_a), .sum_ed_abs(abs_a), .max_ed(max_a), .ovf(ovf_a)
   );

   mul_err_accum #(.W(8), .N_SAMPLES(3), .CNT_W(16), .SUM_W(17)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_bus(bus_b.slave),
      .busy(busy_b), .done(done_b), .sample_cnt(scnt_b), .err_cnt(ecnt_b),
      .sum_ed(sum_b), .sum_ed_abs(abs_b), .max_ed(max_b), .ovf(ovf_b)
   );

   logic              o_ready[2], o_busy[2], o_done[2], o_ovf[2];
   logic [63:0]       o_scnt[2], o_ecnt[2], o_abs[2], o_max[2];
   logic signed [63:0] o_sum[2];

   assign o_ready[0] = bus_a.in_ready;
   assign o_ready[1] = bus_b.in_ready;
   assign o_busy[0]  = busy_a;
   assign o_busy[1]  = busy_b;
   assign o_done[0]  = done_a;
   assign o_done[1]  = done_b;
   assign o_ovf[0]   = ovf_a;
   assign o_ovf[1]   = ovf_b;
   assign o_scnt[0]  = 64'(scnt_a);
   assign o_scnt[1]  = 64'(scnt_b);
   assign o_ecnt[0]  = 64'(ecnt_a);
   assign o_ecnt[1]  = 64'(ecnt_b);
   assign o_abs[0]   = 64'(abs_a);
   assign o_abs[1]   = 64'(abs_b);
   assign o_max[0]   = 64'(max_a);
   assign o_max[1]   = 64'(max_b);
   assign o_sum[0]   = {{24{sum_a[39]}}, sum_a};
   assign o_sum[1]   = {{47{sum_b[16]}}, sum_b};

   // Window-level reference model, one slot per instance.
   int      n_samp[2] = '{4, 3};
   int      sum_w[2]  = '{40, 17};
   int      mode[2];
   int      nacc[2];
   int      drain[2];
   longint  m_err[2];
   longint  m_sum[2];
   longint  m_abs[2];
   longint  m_max[2];
   bit      m_ovf[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic modelClear(input int d);
      nacc[d]  = 0;
      m_err[d] = 0;
      m_sum[d] = 0;
      m_abs[d] = 0;
      m_max[d] = 0;
      m_ovf[d] = 1'b0;
   endtask

   task automatic modelSample(input int d, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] ap);
      longint ex, ed, ab, smax, smin, umax;
      ex   = longint'(a) * longint'(b);
      ed   = ex - longint'(ap);
      ab   = (ed < 0) ? -ed : ed;
      umax = (longint'(1) << sum_w[d]) - 1;
      smax = (longint'(1) << (sum_w[d] - 1)) - 1;
      smin = -(longint'(1) << (sum_w[d] - 1));
      if (ed != 0) m_err[d]++;
      m_sum[d] = m_sum[d] + ed;
      if (m_sum[d] > smax) begin m_sum[d] = smax; m_ovf[d] = 1'b1; end
      if (m_sum[d] < smin) begin m_sum[d] = smin; m_ovf[d] = 1'b1; end
      m_abs[d] = m_abs[d] + ab;
      if (m_abs[d] > umax) begin m_abs[d] = umax; m_ovf[d] = 1'b1; end
      if (ab > m_max[d]) m_max[d] = ab;
   endtask

   task automatic modelEdge(input bit v, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] ap, input bit st);
      for (int d = 0; d < 2; d++) begin
         case (mode[d])
            M_IDLE, M_DONE: if (st) begin modelClear(d); mode[d] = M_RUN; end
            M_RUN: if (v) begin
               modelSample(d, a, b, ap);
               nacc[d]++;
               if (nacc[d] == n_samp[d]) begin mode[d] = M_DRAIN; drain[d] = 3; end
            end
            default: begin
               drain[d]--;
               if (drain[d] == 0) mode[d] = M_DONE;
            end
         endcase
      end
   endtask

   task automatic checkCycle();
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("d%0d.in_ready", d), o_ready[d], mode[d] == M_RUN);
         checkOutput($sformatf("d%0d.busy", d), o_busy[d], (mode[d] == M_RUN) || (mode[d] == M_DRAIN));
         checkOutput($sformatf("d%0d.done", d), o_done[d], mode[d] == M_DONE);
         checkOutput($sformatf("d%0d.sample_cnt", d), o_scnt[d], nacc[d]);
         if (mode[d] == M_IDLE || mode[d] == M_DONE || (mode[d] == M_RUN && nacc[d] == 0)) begin
            checkOutput($sformatf("d%0d.err_cnt", d), o_ecnt[d], m_err[d]);
            checkOutput($sformatf("d%0d.sum_ed", d), o_sum[d], m_sum[d]);
            checkOutput($sformatf("d%0d.sum_ed_abs", d), o_abs[d], m_abs[d]);
            checkOutput($sformatf("d%0d.max_ed", d), o_max[d], m_max[d]);
            checkOutput($sformatf("d%0d.ovf", d), o_ovf[d], m_ovf[d]);
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, model the rising edge, check at the next fall.
   task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] ap, input bit st);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_apprx = ap;
      start    = st;
      @(posedge clk);
      modelEdge(v, a, b, ap, st);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      checkCycle();
   endtask

   task automatic idleUntilDone(input int limit);
      int n;
      n = 0;
      while (!(mode[0] == M_DONE && mode[1] == M_DONE) && n < limit) begin
         applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
         n++;
      end
      checkOutput("window_done", {63'd0, o_done[0] & o_done[1]}, 64'sd1);
   endtask

   task automatic asyncReset();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("rst.d%0d.busy", d), o_busy[d], 64'sd0);
         checkOutput($sformatf("rst.d%0d.done", d), o_done[d], 64'sd0);
         checkOutput($sformatf("rst.d%0d.sample_cnt", d), o_scnt[d], 64'sd0);
         checkOutput($sformatf("rst.d%0d.in_ready", d), o_ready[d], 64'sd0);
         mode[d] = M_IDLE;
         modelClear(d);
      end
      @(negedge clk);
      rst_n = 1'b1;
      checkCycle();
   endtask

   task automatic randomSample(output logic [7:0] a, output logic [7:0] b, output logic [15:0] ap);
      int ex, sel, v;
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      ex  = int'(a) * int'(b);
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
         v = ex;
      end else if (sel == 1) begin
         v = ex + $urandom_range(0, 64) - 32;
         if (v < 0) v = 0;
         if (v > 65535) v = 65535;
      end else begin
         v = $urandom_range(0, 65535);
      end
      ap = 16'(v);
   endtask

   initial begin
      logic [7:0]  a, b;
      logic [15:0] ap;
      bit          vpat[9];
      bit          spat[9];
      int          n;

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_apprx = '0;
      for (int d = 0; d < 2; d++) begin
         mode[d]  = M_IDLE;
         drain[d] = 0;
         modelClear(d);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkCycle();

      // Reset in the middle of an open window.
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
      applyStimulus(1'b1, 8'd12, 8'd13, 16'd100, 1'b0);
      applyStimulus(1'b1, 8'd200, 8'd3, 16'd600, 1'b0);
      asyncReset();
      applyStimulus(1'b1, 8'd5, 8'd5, 16'd25, 1'b0);

      // Exact products only.
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
      applyStimulus(1'b1, 8'd3, 8'd5, 16'd15, 1'b0);
      applyStimulus(1'b1, 8'd255, 8'd255, 16'd65025, 1'b0);
      applyStimulus(1'b1, 8'd0, 8'd7, 16'd0, 1'b0);
      applyStimulus(1'b1, 8'd1, 8'd1, 16'd1, 1'b0);
      idleUntilDone(8);

      // Mixed-sign errors.
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
      applyStimulus(1'b1, 8'd10, 8'd10, 16'd96, 1'b0);
      applyStimulus(1'b1, 8'd20, 8'd5, 16'd104, 1'b0);
      applyStimulus(1'b1, 8'd255, 8'd255, 16'd65000, 1'b0);
      applyStimulus(1'b1, 8'd1, 8'd1, 16'd1, 1'b0);
      idleUntilDone(8);
      checkOutput("err.b.sum_ed", o_sum[1], 64'sd25);
      checkOutput("err.b.sum_ed_abs", o_abs[1], 64'sd33);
      checkOutput("err.b.max_ed", o_max[1], 64'sd25);

      // Gapped valid with a start pulse inside the window and a surplus sample.
      vpat = '{1, 0, 1, 0, 0, 1, 1, 1, 1};
      spat = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         randomSample(a, b, ap);
         applyStimulus(vpat[i], a, b, ap, spat[i]);
      end
      idleUntilDone(8);
      checkOutput("hs.a.sample_cnt", o_scnt[0], 64'sd4);

      // Saturation of the narrow accumulators.
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
      repeat (4) applyStimulus(1'b1, 8'd255, 8'd255, 16'd0, 1'b0);
      idleUntilDone(8);
      checkOutput("sat.b.sum_ed_abs", o_abs[1], 64'sd131071);
      checkOutput("sat.b.ovf", o_ovf[1], 64'sd1);
      checkOutput("sat.b.max_ed", o_max[1], 64'sd65025);

      // Back-to-back random windows, each restarted from DONE.
      for (int w = 0; w < 8; w++) begin
         applyStimulus(1'b0, 8'd0, 8'd0, 16'd0, 1'b1);
         n = 0;
         while (!(mode[0] == M_DONE && mode[1] == M_DONE) && n < 60) begin
            randomSample(a, b, ap);
            applyStimulus($urandom_range(0, 3) != 0, a, b, ap,
                          (mode[0] != M_DONE && mode[1] != M_DONE) && ($urandom_range(0, 7) == 0));
            n++;
         end
         checkOutput("rand.window_done", {63'd0, o_done[0] & o_done[1]}, 64'sd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
